// File: rtl/bridge_int_ctrl_pkg.sv
// rtl/bridge_int_ctrl_pkg.sv - address map, register offsets and interrupt bit indices for the bridge
package bridge_int_ctrl_pkg;

  localparam logic [31:0] DEV0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] DEV1_BASE  = 32'h0000_7F10;
  localparam logic [31:0] ICTRL_BASE = 32'h0000_7F20;

  // Word offsets (PrAddr[3:2]) inside a 16-byte window; offset 3 is outside the 12-byte span.
  localparam logic [1:0] OFF_IMASK = 2'd0;
  localparam logic [1:0] OFF_IPEND = 2'd1;
  localparam logic [1:0] OFF_IMODE = 2'd2;
  localparam logic [1:0] OFF_HOLE  = 2'd3;

  localparam int NSRC      = 3;
  localparam int SRC_DEV0  = 0;
  localparam int SRC_DEV1  = 1;
  localparam int SRC_EXT   = 2;
  localparam int HWINT_LSB = 2;

endpackage

// File: rtl/bridge_int_ctrl_irq_sync_edge.sv
// rtl/bridge_int_ctrl_irq_sync_edge.sv - optional synchroniser plus rising-edge detect for one irq source
module irq_sync_edge #(
  parameter int STAGES = 2,
  parameter bit BYPASS = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_src,
  output logic o_level,
  output logic o_rise
);

  logic w_level;
  logic r_src_d;

  generate
    if (BYPASS) begin : g_bypass
      assign w_level = i_src;
    end else begin : g_sync
      logic [STAGES-1:0] r_sync;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= '0;
        else          r_sync <= {r_sync[STAGES-2:0], i_src};
      end
      assign w_level = r_sync[STAGES-1];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_src_d <= 1'b0;
    else          r_src_d <= w_level;
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_src_d;

endmodule

// File: rtl/bridge_int_ctrl.sv
// rtl/bridge_int_ctrl.sv - Pr-bus bridge to timer0/timer1 with a three-source masked interrupt controller
module bridge_int_ctrl
  import bridge_int_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PrAddr,
  input  logic        PrWE,
  input  logic [31:0] PrWD,
  output logic [31:0] PrRD,
  output logic [1:0]  dev_addr,
  output logic [31:0] dev_wd,
  output logic        dev0_we,
  output logic        dev1_we,
  input  logic [31:0] dev0_rd,
  input  logic [31:0] dev1_rd,
  input  logic [1:0]  dev_irq,
  input  logic        ext_irq,
  output logic [5:0]  HWInt,
  output logic        hit
);

  logic            w_in_span;
  logic            w_sel0;
  logic            w_sel1;
  logic            w_seli;
  logic            w_wr_ictrl;
  logic [NSRC-1:0] w_level;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pend_nxt;
  logic [31:0]     w_ictrl_rd;
  logic            w_unused_addr;

  logic [NSRC-1:0] r_imask;
  logic [NSRC-1:0] r_imode;
  logic [NSRC-1:0] r_pend;

  assign w_in_span     = (PrAddr[3:2] != OFF_HOLE);
  assign w_sel0        = (PrAddr[31:4] == DEV0_BASE[31:4])  && w_in_span;
  assign w_sel1        = (PrAddr[31:4] == DEV1_BASE[31:4])  && w_in_span;
  assign w_seli        = (PrAddr[31:4] == ICTRL_BASE[31:4]) && w_in_span;
  assign w_wr_ictrl    = PrWE && w_seli;
  assign w_unused_addr = ^PrAddr[1:0];

  assign hit      = w_sel0 | w_sel1 | w_seli;
  assign dev_addr = PrAddr[3:2];
  assign dev_wd   = PrWD;
  assign dev0_we  = PrWE & w_sel0;
  assign dev1_we  = PrWE & w_sel1;

  // Timer irqs already live in the clk domain, so only the edge detector is needed there.
  irq_sync_edge #(.STAGES(SYNC_STAGES), .BYPASS(1'b1)) u_sync_dev0 (
    .i_clk(clk), .i_rst_n(reset), .i_src(dev_irq[0]),
    .o_level(w_level[SRC_DEV0]), .o_rise(w_rise[SRC_DEV0])
  );

  irq_sync_edge #(.STAGES(SYNC_STAGES), .BYPASS(1'b1)) u_sync_dev1 (
    .i_clk(clk), .i_rst_n(reset), .i_src(dev_irq[1]),
    .o_level(w_level[SRC_DEV1]), .o_rise(w_rise[SRC_DEV1])
  );

  irq_sync_edge #(.STAGES(SYNC_STAGES), .BYPASS(1'b0)) u_sync_ext (
    .i_clk(clk), .i_rst_n(reset), .i_src(ext_irq),
    .o_level(w_level[SRC_EXT]), .o_rise(w_rise[SRC_EXT])
  );

  // W1C only touches edge-mode bits; a new edge in the clearing cycle keeps the bit set.
  always_comb begin
    w_clr      = (w_wr_ictrl && PrAddr[3:2] == OFF_IPEND) ? PrWD[NSRC-1:0] : '0;
    w_pend_nxt = r_pend;
    for (int i = 0; i < NSRC; i++) begin
      if (r_imode[i]) w_pend_nxt[i] = w_rise[i] | (r_pend[i] & ~w_clr[i]);
      else            w_pend_nxt[i] = w_level[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_imask <= '0;
      r_imode <= '0;
      r_pend  <= '0;
    end else begin
      if (w_wr_ictrl && PrAddr[3:2] == OFF_IMASK) r_imask <= PrWD[NSRC-1:0];
      if (w_wr_ictrl && PrAddr[3:2] == OFF_IMODE) r_imode <= PrWD[NSRC-1:0];
      r_pend <= w_pend_nxt;
    end
  end

  always_comb begin
    w_ictrl_rd = '0;
    case (PrAddr[3:2])
      OFF_IMASK: w_ictrl_rd[NSRC-1:0] = r_imask;
      OFF_IPEND: w_ictrl_rd[NSRC-1:0] = r_pend;
      OFF_IMODE: w_ictrl_rd[NSRC-1:0] = r_imode;
      default:   w_ictrl_rd = '0;
    endcase
  end

  always_comb begin
    PrRD = '0;
    if (w_sel0)      PrRD = dev0_rd;
    else if (w_sel1) PrRD = dev1_rd;
    else if (w_seli) PrRD = w_ictrl_rd;
  end

  assign HWInt = {3'b000, r_pend & r_imask};

endmodule

// File: tb/tb_bridge_int_ctrl.sv
// tb/tb_bridge_int_ctrl.sv - directed, table-driven bench for bridge_int_ctrl
module tb_bridge_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PrAddr;
  logic        PrWE;
  logic [31:0] PrWD;
  logic [31:0] PrRD;
  logic [1:0]  dev_addr;
  logic [31:0] dev_wd;
  logic        dev0_we;
  logic        dev1_we;
  logic [31:0] dev0_rd;
  logic [31:0] dev1_rd;
  logic [1:0]  dev_irq;
  logic        ext_irq;
  logic [5:0]  HWInt;
  logic        hit;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bridge_int_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(rst_n), .PrAddr(PrAddr), .PrWE(PrWE), .PrWD(PrWD), .PrRD(PrRD),
    .dev_addr(dev_addr), .dev_wd(dev_wd), .dev0_we(dev0_we), .dev1_we(dev1_we),
    .dev0_rd(dev0_rd), .dev1_rd(dev1_rd), .dev_irq(dev_irq), .ext_irq(ext_irq),
    .HWInt(HWInt), .hit(hit)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        d0we;
    logic        d1we;
    logic        hit;
    logic [1:0]  daddr;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    PrAddr = addr; PrWE = 1'b1; PrWD = data;
    @(posedge clk); #1;
    PrWE = 1'b0; PrAddr = 32'h0; PrWD = 32'h0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    PrAddr = addr; PrWE = 1'b0;
    #1;
    chk(name, PrRD, exp);
    PrAddr = 32'h0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h0000_7F04, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 32'hAAAA_0000};
    vecs[1]  = '{32'h0000_7F0C, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'h0000_0000};
    vecs[2]  = '{32'h0000_7F0B, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'hAAAA_0000};
    vecs[3]  = '{32'h0000_7F10, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_BBBB};
    vecs[4]  = '{32'h0000_7F1B, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0000_BBBB};
    vecs[5]  = '{32'h0000_7F1C, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'h0000_0000};
    vecs[6]  = '{32'h0000_7F20, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0000};
    vecs[7]  = '{32'h0000_7F2C, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'h0000_0000};
    vecs[8]  = '{32'h0000_7EFF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'h0000_0000};
    vecs[9]  = '{32'h0001_7F04, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h0000_0000};
    vecs[10] = '{32'h0000_7F30, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_0000};

    rst_n = 1'b0; PrAddr = 32'h0; PrWE = 1'b0; PrWD = 32'h0;
    dev0_rd = 32'hAAAA_0000; dev1_rd = 32'h0000_BBBB; dev_irq = 2'b00; ext_irq = 1'b0;
    cycles(2);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    chk("reset_hwint", {26'd0, HWInt}, 32'h0);
    rd_chk("reset_imask", 32'h0000_7F20, 32'h0);
    rd_chk("reset_ipend", 32'h0000_7F24, 32'h0);
    rd_chk("reset_imode", 32'h0000_7F28, 32'h0);

    // T1 decode table, applied and released within a low clock phase so no ICTRL write lands
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      PrAddr = vecs[i].addr; PrWE = vecs[i].we; PrWD = 32'h5 + i;
      #1;
      chk($sformatf("dec%0d_dev0_we", i), {31'd0, dev0_we}, {31'd0, vecs[i].d0we});
      chk($sformatf("dec%0d_dev1_we", i), {31'd0, dev1_we}, {31'd0, vecs[i].d1we});
      chk($sformatf("dec%0d_hit", i), {31'd0, hit}, {31'd0, vecs[i].hit});
      chk($sformatf("dec%0d_dev_addr", i), {30'd0, dev_addr}, {30'd0, vecs[i].daddr});
      chk($sformatf("dec%0d_prrd", i), PrRD, vecs[i].rd);
      chk($sformatf("dec%0d_dev_wd", i), dev_wd, 32'h5 + i);
      PrWE = 1'b0; PrAddr = 32'h0;
    end
    @(posedge clk); #1;

    // T2 level mode on dev_irq[0]
    wr(32'h0000_7F20, 32'h1);
    dev_irq[0] = 1'b1;
    #1 chk("t2_before_edge", {26'd0, HWInt}, 32'h0);
    @(posedge clk); #1;
    chk("t2_level_set", {26'd0, HWInt}, 32'h1);
    dev_irq[0] = 1'b0;
    #1 chk("t2_level_hold", {26'd0, HWInt}, 32'h1);
    @(posedge clk); #1;
    chk("t2_level_drop", {26'd0, HWInt}, 32'h0);

    // T3 edge mode on dev_irq[1] with write-1-to-clear
    wr(32'h0000_7F28, 32'h2);
    wr(32'h0000_7F20, 32'h2);
    dev_irq[1] = 1'b1;
    @(posedge clk); #1;
    dev_irq[1] = 1'b0;
    chk("t3_edge_set", {26'd0, HWInt}, 32'h2);
    cycles(3);
    chk("t3_edge_held", {26'd0, HWInt}, 32'h2);
    wr(32'h0000_7F24, 32'h1);
    chk("t3_w1c_other_bit", {26'd0, HWInt}, 32'h2);
    wr(32'h0000_7F24, 32'h2);
    chk("t3_w1c_clear", {26'd0, HWInt}, 32'h0);
    dev_irq[1] = 1'b1;
    PrAddr = 32'h0000_7F24; PrWE = 1'b1; PrWD = 32'h2;
    @(posedge clk); #1;
    PrWE = 1'b0; PrAddr = 32'h0; dev_irq[1] = 1'b0;
    chk("t3_set_wins", {26'd0, HWInt}, 32'h2);
    rd_chk("t3_read_ipend", 32'h0000_7F24, 32'h2);
    wr(32'h0000_7F24, 32'h2);
    chk("t3_final_clear", {26'd0, HWInt}, 32'h0);

    // T4 ext_irq through the synchroniser, level mode
    wr(32'h0000_7F20, 32'h4);
    @(negedge clk); ext_irq = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t4_ext_edge%0d", k), {26'd0, HWInt}, (k == 3) ? 32'h4 : 32'h0);
    end
    ext_irq = 1'b0;
    cycles(4);
    chk("t4_ext_drop", {26'd0, HWInt}, 32'h0);

    // T5 masking of latched pending bits
    wr(32'h0000_7F20, 32'h0);
    wr(32'h0000_7F28, 32'h7);
    dev_irq = 2'b11; ext_irq = 1'b1;
    @(posedge clk); #1;
    dev_irq = 2'b00;
    cycles(5);
    ext_irq = 1'b0;
    chk("t5_masked", {26'd0, HWInt}, 32'h0);
    rd_chk("t5_read_ipend", 32'h0000_7F24, 32'h7);
    cycles(4);
    wr(32'h0000_7F20, 32'h7);
    chk("t5_unmasked", {26'd0, HWInt}, 32'h7);
    rd_chk("t5_read_imask", 32'h0000_7F20, 32'h7);
    rd_chk("t5_read_imode", 32'h0000_7F28, 32'h7);

    // T6 asynchronous reset in the middle of an ICTRL write
    @(posedge clk); #3;
    PrAddr = 32'h0000_7F20; PrWE = 1'b1; PrWD = 32'h5;
    rst_n = 1'b0;
    #1 chk("t6_async_clear", {26'd0, HWInt}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    PrWE = 1'b0; PrAddr = 32'h0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_hwint_after", {26'd0, HWInt}, 32'h0);
    rd_chk("t6_imask", 32'h0000_7F20, 32'h0);
    rd_chk("t6_ipend", 32'h0000_7F24, 32'h0);
    rd_chk("t6_imode", 32'h0000_7F28, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
